// File: rtl/ma_pkg.sv
// Shared encodings and default sizing for the result checker.
package ma_pkg;

    localparam int DW_DEF      = 36;
    localparam int AW_DEF      = 8;
    localparam int CW_DEF      = 16;
    localparam int NBW         = 10;
    localparam int MAX_BATCHES = 2 ** AW_DEF;

    // Two compare-pipeline cycles must be allowed to retire after ctl_done.
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ma_result_ram.sv
// Simple dual-port result buffer: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module ma_result_ram #(
    parameter int DW = 36,
    parameter int AW = 8
) (
    input  logic          s_clk,
    input  logic          aclr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge s_clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    always_ff @(posedge s_clk or posedge aclr) begin
        if (aclr) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/ma_result_check.sv
// Checks popped accumulator results against a golden ROM and keeps run statistics.
// state   | meaning
// IDLE    | no run active, pops ignored
// ARMED   | start seen, waiting for the first pop
// CAPTURE | pops being compared and stored
// DRAIN   | controller done, letting in-flight compares retire
// DONE    | results final, done/pass valid until the next start
module ma_result_check
    import ma_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic           s_clk,
    input  logic           aclr,
    input  logic           start,
    input  logic [NBW-1:0] num_batches,
    input  logic           rd_req,
    input  logic [DW-1:0]  fifo_q,
    input  logic           fifo_empty,
    input  logic           corr_flag,
    input  logic           ctl_done,
    output logic [AW-1:0]  exp_adr,
    input  logic [DW-1:0]  exp_q,
    input  logic [AW-1:0]  host_adr,
    output logic [DW-1:0]  host_q,
    output logic [CW-1:0]  match_cnt,
    output logic [CW-1:0]  mism_cnt,
    output logic [CW-1:0]  corr_cnt,
    output logic           underflow,
    output logic           overflow,
    output logic           done,
    output logic           pass
);

    localparam int            IW      = AW + 1;
    localparam int            NB_MAX  = 2 ** AW;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [1:0]    DRAIN_LOAD = 2'(DRAIN_CYC - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] nb_q, nb_d;
    logic [IW-1:0] nb_clamp;
    logic [1:0]    drain_cnt_q, drain_cnt_d;
    logic          s1_vld_q, s1_vld_d;
    logic [AW-1:0] s1_adr_q, s1_adr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_adr_q, wr_adr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic [CW-1:0] mism_cnt_q, mism_cnt_d;
    logic [CW-1:0] corr_cnt_q, corr_cnt_d;
    logic          underflow_q, underflow_d;
    logic          overflow_q, overflow_d;

    logic          pop_window;
    logic          pop_req;
    logic          pop_acc;
    logic          pop_keep;

    // The buffer only holds 2**AW words, so larger batch counts are clamped.
    always_comb begin
        if (int'(num_batches) > NB_MAX) begin
            nb_clamp = IW'(NB_MAX);
        end else begin
            nb_clamp = IW'(int'(num_batches));
        end
    end

    assign pop_window = (state_q == ST_ARMED) || (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign pop_req    = pop_window && rd_req && !start;
    assign pop_acc    = pop_req && !fifo_empty;
    assign pop_keep   = pop_acc && (idx_q != nb_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nb_d        = nb_q;
        drain_cnt_d = drain_cnt_q;
        s1_vld_d    = 1'b0;
        s1_adr_d    = s1_adr_q;
        wr_en_d     = 1'b0;
        wr_adr_d    = wr_adr_q;
        wr_data_d   = wr_data_q;
        match_cnt_d = match_cnt_q;
        mism_cnt_d  = mism_cnt_q;
        corr_cnt_d  = corr_cnt_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;

        if (start) begin
            // In-flight compares from a previous run are dropped with the counters.
            state_d     = ST_ARMED;
            idx_d       = '0;
            nb_d        = nb_clamp;
            drain_cnt_d = '0;
            match_cnt_d = '0;
            mism_cnt_d  = '0;
            corr_cnt_d  = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (ctl_done) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end else if (rd_req) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (ctl_done) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (pop_req) begin
                        drain_cnt_d = DRAIN_LOAD;
                    end else if (drain_cnt_q == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 2'd1;
                    end
                end
                ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase

            if (pop_req && fifo_empty) begin
                underflow_d = 1'b1;
            end
            if (pop_acc && !pop_keep) begin
                overflow_d = 1'b1;
            end
            if (pop_keep) begin
                idx_d = idx_q + IDX_ONE;
            end

            s1_vld_d = pop_keep;
            s1_adr_d = idx_q[AW-1:0];

            if (s1_vld_q) begin
                wr_en_d   = 1'b1;
                wr_adr_d  = s1_adr_q;
                wr_data_d = fifo_q;
                if (fifo_q == exp_q) begin
                    if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CNT_ONE;
                end else begin
                    if (mism_cnt_q != '1) mism_cnt_d = mism_cnt_q + CNT_ONE;
                end
                if (corr_flag && (corr_cnt_q != '1)) begin
                    corr_cnt_d = corr_cnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge s_clk or posedge aclr) begin
        if (aclr) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            nb_q        <= '0;
            drain_cnt_q <= '0;
            s1_vld_q    <= 1'b0;
            s1_adr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
            match_cnt_q <= '0;
            mism_cnt_q  <= '0;
            corr_cnt_q  <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nb_q        <= nb_d;
            drain_cnt_q <= drain_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_adr_q    <= s1_adr_d;
            wr_en_q     <= wr_en_d;
            wr_adr_q    <= wr_adr_d;
            wr_data_q   <= wr_data_d;
            match_cnt_q <= match_cnt_d;
            mism_cnt_q  <= mism_cnt_d;
            corr_cnt_q  <= corr_cnt_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    ma_result_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .s_clk   (s_clk),
        .aclr    (aclr),
        .wr_en   (wr_en_q),
        .wr_adr  (wr_adr_q),
        .wr_data (wr_data_q),
        .rd_adr  (host_adr),
        .rd_data (host_q)
    );

    assign exp_adr   = idx_q[AW-1:0];
    assign match_cnt = match_cnt_q;
    assign mism_cnt  = mism_cnt_q;
    assign corr_cnt  = corr_cnt_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (mism_cnt_q == '0) && !underflow_q && !overflow_q && (idx_q == nb_q);

endmodule

// File: tb/tb_ma_result_check.sv
// Directed table-driven bench for ma_result_check with a behavioural golden ROM.
module tb_ma_result_check;

    logic        s_clk = 1'b0;
    logic        aclr;
    logic        start;
    logic [9:0]  num_batches;
    logic        rd_req;
    logic [35:0] fifo_q;
    logic        fifo_empty;
    logic        corr_flag;
    logic        ctl_done;
    logic [7:0]  exp_adr;
    logic [35:0] exp_q;
    logic [7:0]  host_adr;
    logic [35:0] host_q;
    logic [15:0] match_cnt, mism_cnt, corr_cnt;
    logic        underflow, overflow, done, pass;

    int checks = 0;
    int errors = 0;

    logic [35:0] gold [256];

    always #5 s_clk = ~s_clk;

    always_ff @(posedge s_clk) exp_q <= gold[exp_adr];

    ma_result_check dut (
        .s_clk       (s_clk),
        .aclr        (aclr),
        .start       (start),
        .num_batches (num_batches),
        .rd_req      (rd_req),
        .fifo_q      (fifo_q),
        .fifo_empty  (fifo_empty),
        .corr_flag   (corr_flag),
        .ctl_done    (ctl_done),
        .exp_adr     (exp_adr),
        .exp_q       (exp_q),
        .host_adr    (host_adr),
        .host_q      (host_q),
        .match_cnt   (match_cnt),
        .mism_cnt    (mism_cnt),
        .corr_cnt    (corr_cnt),
        .underflow   (underflow),
        .overflow    (overflow),
        .done        (done),
        .pass        (pass)
    );

    typedef struct {
        int         nb;
        int         npops;
        logic [7:0] mism_m;
        logic [7:0] corr_m;
        logic [7:0] empty_m;
        int         e_match;
        int         e_mism;
        int         e_corr;
        logic       e_unf;
        logic       e_ovf;
        logic       e_pass;
        int         e_idx;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input int nb);
        start       = 1'b1;
        num_batches = 10'(nb);
        ctl_done    = 1'b0;
        rd_req      = 1'b0;
        @(negedge s_clk);
        start = 1'b0;
    endtask

    // Pop in this cycle, present FIFO data in the next one.
    task automatic do_pop(input logic [35:0] d, input logic corr, input logic empty);
        rd_req     = 1'b1;
        fifo_empty = empty;
        @(negedge s_clk);
        rd_req     = 1'b0;
        fifo_empty = 1'b0;
        if (!empty) begin
            fifo_q    = d;
            corr_flag = corr;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        ctl_done = 1'b1;
        while (!done && cyc < 20) begin
            @(negedge s_clk);
            cyc++;
        end
    endtask

    task automatic read_host(input int a, output logic [35:0] q);
        host_adr = 8'(a);
        @(negedge s_clk);
        q = host_q;
    endtask

    initial begin
        int          acc;
        int          cyc;
        logic [35:0] d;
        logic [35:0] rq;

        for (int i = 0; i < 256; i++) begin
            gold[i] = {4'h5, 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000};
        end

        vt[0] = '{nb: 4, npops: 4, mism_m: 8'h00, corr_m: 8'h00, empty_m: 8'h00,
                  e_match: 4, e_mism: 0, e_corr: 0, e_unf: 0, e_ovf: 0, e_pass: 1, e_idx: 4};
        vt[1] = '{nb: 3, npops: 3, mism_m: 8'h02, corr_m: 8'h04, empty_m: 8'h00,
                  e_match: 2, e_mism: 1, e_corr: 1, e_unf: 0, e_ovf: 0, e_pass: 0, e_idx: 3};
        vt[2] = '{nb: 3, npops: 3, mism_m: 8'h00, corr_m: 8'h00, empty_m: 8'h02,
                  e_match: 2, e_mism: 0, e_corr: 0, e_unf: 1, e_ovf: 0, e_pass: 0, e_idx: 2};
        vt[3] = '{nb: 2, npops: 3, mism_m: 8'h00, corr_m: 8'h00, empty_m: 8'h00,
                  e_match: 2, e_mism: 0, e_corr: 0, e_unf: 0, e_ovf: 1, e_pass: 0, e_idx: 2};
        vt[4] = '{nb: 0, npops: 0, mism_m: 8'h00, corr_m: 8'h00, empty_m: 8'h00,
                  e_match: 0, e_mism: 0, e_corr: 0, e_unf: 0, e_ovf: 0, e_pass: 1, e_idx: 0};
        vt[5] = '{nb: 2, npops: 2, mism_m: 8'h03, corr_m: 8'h03, empty_m: 8'h00,
                  e_match: 0, e_mism: 2, e_corr: 2, e_unf: 0, e_ovf: 0, e_pass: 0, e_idx: 2};

        aclr = 1'b1; start = 1'b0; num_batches = '0; rd_req = 1'b0; fifo_q = '0;
        fifo_empty = 1'b0; corr_flag = 1'b0; ctl_done = 1'b0; host_adr = '0;
        repeat (2) @(posedge s_clk);
        @(negedge s_clk);
        chk("rst_match", 64'(match_cnt), 0);
        chk("rst_mism", 64'(mism_cnt), 0);
        chk("rst_corr", 64'(corr_cnt), 0);
        chk("rst_flags", {underflow, overflow, done, pass}, 0);
        chk("rst_exp_adr", 64'(exp_adr), 0);
        chk("rst_host_q", 64'(host_q), 0);
        aclr = 1'b0;
        @(negedge s_clk);

        for (int k = 0; k < 6; k++) begin
            do_start(vt[k].nb);
            acc = 0;
            for (int i = 0; i < vt[k].npops; i++) begin
                d = '0;
                if (!vt[k].empty_m[i]) begin
                    d = (acc >= vt[k].nb) ? 36'hF_DEAD_BEEF
                                          : gold[acc] ^ (vt[k].mism_m[i] ? 36'h1 : 36'h0);
                    acc++;
                end
                do_pop(d, vt[k].corr_m[i], vt[k].empty_m[i]);
            end
            wait_done(cyc);
            chk($sformatf("v%0d_done", k), 64'(done), 1);
            chk($sformatf("v%0d_match", k), 64'(match_cnt), 64'(vt[k].e_match));
            chk($sformatf("v%0d_mism", k), 64'(mism_cnt), 64'(vt[k].e_mism));
            chk($sformatf("v%0d_corr", k), 64'(corr_cnt), 64'(vt[k].e_corr));
            chk($sformatf("v%0d_underflow", k), 64'(underflow), 64'(vt[k].e_unf));
            chk($sformatf("v%0d_overflow", k), 64'(overflow), 64'(vt[k].e_ovf));
            chk($sformatf("v%0d_pass", k), 64'(pass), 64'(vt[k].e_pass));
            chk($sformatf("v%0d_idx", k), 64'(exp_adr), 64'(vt[k].e_idx));

            if (k == 0) begin
                for (int a = 0; a < 4; a++) begin
                    read_host(a, rq);
                    chk($sformatf("buf0_%0d", a), 64'(rq), 64'(gold[a]));
                end
            end
            if (k == 1) begin
                read_host(1, rq);
                chk("buf1_flipped", 64'(rq), 64'(gold[1] ^ 36'h1));
            end
            if (k == 3) begin
                read_host(2, rq);
                chk("ovf_word_absent", 64'(rq), 64'(gold[2]));
            end
            if (k == 4) begin
                chk("nb0_latency_le3", 64'(cyc <= 3), 1);
            end
            if (k == 5) begin
                do_start(1);
                chk("restart_match", 64'(match_cnt), 0);
                chk("restart_mism", 64'(mism_cnt), 0);
                chk("restart_corr", 64'(corr_cnt), 0);
                chk("restart_flags", {underflow, overflow, done, pass}, 0);
            end
        end

        // Pop in the same cycle the controller signals done.
        do_start(1);
        rd_req = 1'b1; fifo_empty = 1'b0; ctl_done = 1'b1;
        @(negedge s_clk);
        rd_req = 1'b0; fifo_q = gold[0]; corr_flag = 1'b0;
        wait_done(cyc);
        chk("same_cyc_done", 64'(done), 1);
        chk("same_cyc_match", 64'(match_cnt), 1);
        chk("same_cyc_pass", 64'(pass), 1);

        // Reset in the middle of a capture, then a fresh run.
        do_start(4);
        do_pop(gold[0], 1'b0, 1'b0);
        do_pop(gold[1], 1'b0, 1'b0);
        chk("mid_match", 64'(match_cnt), 1);
        chk("mid_done", 64'(done), 0);
        aclr = 1'b1;
        @(posedge s_clk);
        #1;
        chk("aclr_counts", {16'(0), match_cnt, mism_cnt, corr_cnt}, 0);
        chk("aclr_flags", {underflow, overflow, done, pass}, 0);
        chk("aclr_exp_adr", 64'(exp_adr), 0);
        chk("aclr_host_q", 64'(host_q), 0);
        @(negedge s_clk);
        aclr = 1'b0;
        @(negedge s_clk);
        do_start(2);
        do_pop(gold[0], 1'b0, 1'b0);
        do_pop(gold[1], 1'b0, 1'b0);
        wait_done(cyc);
        chk("post_rst_done", 64'(done), 1);
        chk("post_rst_match", 64'(match_cnt), 2);
        chk("post_rst_pass", 64'(pass), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
